ram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port-write/single-port-read `ram` data memory. Requester 0 (core load/store unit) and requester 1 (debug/program loader) are shared onto the RAM by round-robin arbitration. Reads are sequenced around the RAM's registered read address. Byte-masked writes are handled by read-modify-write, so neither requester needs to know the RAM is word-only.

---
 rtl/ram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares a word-only RAM (one write port, one registered-address read port)
//   between two requesters. m0 is the core load/store unit, m1 the debug /
//   program loader. Round-robin arbitration; one transaction in flight at a
//   time. Byte-masked writes are turned into read-modify-write sequences.
//
//   Handshake: a requester holds req (and its command) until gnt is high in
//   the same cycle; gnt is combinational and only issued in IDLE. Exactly one
//   rvalid pulse follows each grant (reads and writes). rdata is valid only
//   with rvalid and is 0 otherwise.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   mX_req_i/we_i/addr_i      request, 1=write, byte address ([1:0] ignored)
//   mX_wdata_i/be_i           write data, byte enables
//   mX_gnt_o                  request accepted this cycle
//   mX_rvalid_o/rdata_o       completion pulse, read data
//   ram_wr_en_o/addr_o/data_o RAM write port
//   ram_rd_addr_o             RAM read address (registered by RAM when no write)
//   ram_rd_data_i             RAM read data for the address registered last edge
//   state_o                   FSM state (0=IDLE, 1=RMW, 2=RESP) for observation
module ram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                m0_req_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_be_i,
   output logic                m0_gnt_o,
   output logic                m0_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   input  logic                m1_req_i,
   input  logic                m1_we_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_be_i,
   output logic                m1_gnt_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                ram_wr_en_o,
   output logic [ADDR_W-1:0]   ram_wr_addr_o,
   output logic [DATA_W-1:0]   ram_wr_data_o,
   output logic [ADDR_W-1:0]   ram_rd_addr_o,
   input  logic [DATA_W-1:0]   ram_rd_data_i,
   output logic [1:0]          state_o
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RMW  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_q;
   logic                own_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;

   logic                any_req;
   logic                sel;
   logic                grant;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [BE_W-1:0]     sel_be;
   logic [DATA_W-1:0]   merged;

   // On contention the requester that was not granted last wins; otherwise
   // whichever one is requesting.
   assign any_req   = m0_req_i | m1_req_i;
   assign sel       = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
   assign grant     = (state_q == IDLE) & any_req;
   assign sel_we    = sel ? m1_we_i    : m0_we_i;
   assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
   assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
   assign sel_be    = sel ? m1_be_i    : m0_be_i;

   assign state_o   = state_q;

   // RMW merge: RAM already holds the old word at the latched address because
   // the read address was registered in the grant cycle.
   always_comb begin
      merged = ram_rd_data_i;
      for (int i = 0; i < BE_W; i++) begin
         if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         own_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            last_q  <= sel;
            own_q   <= sel;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            be_q    <= sel_be;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      m0_gnt_o      = 1'b0;
      m1_gnt_o      = 1'b0;
      m0_rvalid_o   = 1'b0;
      m1_rvalid_o   = 1'b0;
      m0_rdata_o    = '0;
      m1_rdata_o    = '0;
      ram_wr_en_o   = 1'b0;
      ram_rd_addr_o = addr_q;
      ram_wr_addr_o = addr_q;
      ram_wr_data_o = wdata_q;

      unique case (state_q)
         IDLE: begin
            ram_rd_addr_o = m0_addr_i;
            if (any_req) begin
               m0_gnt_o      = ~sel;
               m1_gnt_o      = sel;
               ram_rd_addr_o = sel_addr;
               if (!sel_we) begin
                  state_d = RESP;
               end else if (&sel_be) begin
                  ram_wr_en_o   = 1'b1;
                  ram_wr_addr_o = sel_addr;
                  ram_wr_data_o = sel_wdata;
                  state_d       = RESP;
               end else if (|sel_be) begin
                  state_d = RMW;
               end else begin
                  // be=0: acknowledge without touching the RAM
                  state_d = RESP;
               end
            end
         end
         RMW: begin
            ram_wr_en_o   = 1'b1;
            ram_wr_data_o = merged;
            state_d       = RESP;
         end
         RESP: begin
            // Read address stays on addr_q, so the RAM keeps presenting the
            // word (including one written the cycle before).
            state_d = IDLE;
            if (own_q) begin
               m1_rvalid_o = 1'b1;
               m1_rdata_o  = we_q ? '0 : ram_rd_data_i;
            end else begin
               m0_rvalid_o = 1'b1;
               m0_rdata_o  = we_q ? '0 : ram_rd_data_i;
            end
         end
         default: state_d = IDLE;
      endcase

      // While reset is asserted nothing leaves the block, in particular no
      // grant and no pending RMW write.
      if (!rst_n_i) begin
         state_d       = IDLE;
         m0_gnt_o      = 1'b0;
         m1_gnt_o      = 1'b0;
         m0_rvalid_o   = 1'b0;
         m1_rvalid_o   = 1'b0;
         m0_rdata_o    = '0;
         m1_rdata_o    = '0;
         ram_wr_en_o   = 1'b0;
         ram_rd_addr_o = '0;
         ram_wr_addr_o = '0;
         ram_wr_data_o = '0;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Bench for ram_arbiter: RAM model, requester drivers, reference model with
//   expected-response queue, monitor, final RAM comparison and summary.
module tb_ram_arbiter;

   typedef struct packed {
      logic        owner;
      logic        we;
      logic [3:0]  be;
      logic [3:0]  word;
      logic [1:0]  lat;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- DUT signals ----------------
   logic        req [2];
   logic        we [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic [3:0]  be [2];
   logic        gnt [2];
   logic        rvalid [2];
   logic [31:0] rdata [2];
   logic        ram_wr_en;
   logic [31:0] ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_data;
   logic [1:0]  dbg_state;

   ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
      .m0_wdata_i(wdata[0]), .m0_be_i(be[0]),
      .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]), .m0_rdata_o(rdata[0]),
      .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
      .m1_wdata_i(wdata[1]), .m1_be_i(be[1]),
      .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]), .m1_rdata_o(rdata[1]),
      .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr),
      .ram_wr_data_o(ram_wr_data), .ram_rd_addr_o(ram_rd_addr),
      .ram_rd_data_i(ram_rd_data), .state_o(dbg_state)
   );

   // ---------------- RAM model (16 words) ----------------
   logic [31:0] ram_mem [16];
   logic [31:0] rd_addr_q = '0;
   logic        ld_en = 1'b0;
   logic [3:0]  ld_idx = '0;
   logic [31:0] ld_data = '0;
   always @(posedge clk) begin
      if (ld_en) ram_mem[ld_idx] <= ld_data;
      else if (ram_wr_en) ram_mem[ram_wr_addr[5:2]] <= ram_wr_data;
      else rd_addr_q <= ram_rd_addr;
   end
   assign ram_rd_data = ram_mem[rd_addr_q[5:2]];

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] ref_mem [16];
   exp_t        exp_q[$];
   int          n_assert = 0;
   int          n_fail = 0;
   logic        m_last = 1'b1;
   int          gnt_cyc = 0;
   logic        pend = 1'b0;
   logic [3:0]  pend_word = '0;
   logic [31:0] pend_data = '0;
   logic [31:0] last_rd = '0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] b);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs",
             {gnt[0], gnt[1], rvalid[0], rvalid[1], ram_wr_en, dbg_state,
              |rdata[0], |rdata[1], |ram_rd_addr, |ram_wr_addr, |ram_wr_data}, 64'd0);
         exp_q.delete();
         pend   = 1'b0;
         m_last = 1'b1;
      end else begin
         logic exp_wr;
         logic [3:0]  exp_wword;
         logic [31:0] exp_wdata;
         exp_wr    = pend;
         exp_wword = pend_word;
         exp_wdata = pend_data;
         pend      = 1'b0;

         chk("gnt_exclusive", {63'd0, gnt[0] & gnt[1]}, 64'd0);

         for (int p = 0; p < 2; p++) begin
            if (rvalid[p]) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rvalid", {63'd0, rvalid[p]}, 64'd0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("rvalid_owner", 64'(p), 64'(e.owner));
                  chk("rdata", 64'(rdata[p]), 64'(e.rdata));
                  chk("latency", 64'(cyc - gnt_cyc), 64'(e.lat));
                  if (e.we) ref_mem[e.word] = apply_be(ref_mem[e.word], e.wdata, e.be);
                  last_rd = rdata[p];
               end
            end else begin
               chk("rdata_idle_zero", 64'(rdata[p]), 64'd0);
            end
         end

         for (int p = 0; p < 2; p++) begin
            if (gnt[p]) begin
               exp_t e;
               chk("gnt_has_req", {63'd0, req[p]}, 64'd1);
               if (req[0] && req[1]) chk("round_robin", 64'(p), 64'(!m_last));
               m_last  = p[0];
               gnt_cyc = cyc;
               e.owner = p[0];
               e.we    = we[p];
               e.be    = be[p];
               e.word  = addr[p][5:2];
               e.wdata = wdata[p];
               e.rdata = we[p] ? 32'd0 : ref_mem[addr[p][5:2]];
               e.lat   = (we[p] && be[p] != 4'hF && be[p] != 4'h0) ? 2'd2 : 2'd1;
               exp_q.push_back(e);
               if (we[p] && be[p] == 4'hF) begin
                  exp_wr    = 1'b1;
                  exp_wword = e.word;
                  exp_wdata = wdata[p];
               end else if (we[p] && be[p] != 4'h0) begin
                  pend      = 1'b1;
                  pend_word = e.word;
                  pend_data = apply_be(ref_mem[e.word], wdata[p], be[p]);
               end
            end
         end

         chk("ram_wr_en", {63'd0, ram_wr_en}, {63'd0, exp_wr});
         if (exp_wr && ram_wr_en) begin
            chk("ram_wr_word", 64'(ram_wr_addr[31:2]), 64'(exp_wword));
            chk("ram_wr_data", 64'(ram_wr_data), 64'(exp_wdata));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      int waited;
      req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
      waited = 0;
      forever begin
         @(negedge clk);
         if (gnt[p]) break;
         waited++;
         if (waited > 64) begin
            chk("grant_timeout", {63'd0, gnt[p]}, 64'd1);
            break;
         end
      end
      @(posedge clk); #1;
      req[p] = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || pend) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic rand_driver(input int p, input int n);
      logic [3:0] b;
      int r;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         r = $urandom_range(0, 3);
         b = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom);
         issue(p, 1'($urandom_range(0, 1)),
               32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
               $urandom, b);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0; be[p] = '0;
      end
      // preload RAM and reference while in reset
      for (int i = 0; i < 16; i++) begin
         logic [31:0] v;
         v = (i == 4) ? 32'hDEADBEEF : (i == 2) ? 32'hAABBCCDD : $urandom;
         ref_mem[i] = v;
         ld_en = 1'b1; ld_idx = 4'(i); ld_data = v;
         @(posedge clk); #1;
         // request present during reset must not be granted
         req[0] = (i >= 13 && i < 15);
         addr[0] = 32'h10;
      end
      ld_en = 1'b0;
      req[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // read after reset
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
      wait_done();
      chk("read_after_reset", 64'(last_rd), 64'hDEADBEEF);

      // full write then read
      issue(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
      issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
      wait_done();
      chk("full_write_read", 64'(last_rd), 64'h12345678);

      // partial write (RMW) then read; low address bits are ignored
      issue(0, 1'b1, 32'h08, 32'h11223344, 4'b0101);
      issue(0, 1'b0, 32'h0B, 32'h0, 4'h0);
      wait_done();
      chk("rmw_read", 64'(last_rd), 64'hAA22CC44);

      // be=0 write leaves word untouched
      issue(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
      issue(1, 1'b0, 32'h10, 32'h0, 4'h0);
      wait_done();
      chk("be0_unchanged", 64'(last_rd), 64'hDEADBEEF);

      // contention from reset: alternating grants starting with m0
      pulse_reset();
      fork
         for (int k = 0; k < 6; k++) issue(0, 1'b0, 32'(k * 4), 32'h0, 4'h0);
         for (int k = 0; k < 6; k++) issue(1, 1'b0, 32'(k * 4 + 32), 32'h0, 4'h0);
      join
      wait_done();

      // reset in the middle of an RMW: no write, no rvalid
      issue(0, 1'b1, 32'h08, 32'h55667788, 4'b0011);
      rst_n = 1'b0;
      #1;
      chk("rmw_reset_wr_en", {63'd0, ram_wr_en}, 64'd0);
      chk("rmw_reset_rvalid", {62'd0, rvalid[0], rvalid[1]}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      issue(1, 1'b0, 32'h08, 32'h0, 4'h0);
      wait_done();
      chk("rmw_abandoned", 64'(last_rd), 64'hAA22CC44);

      // randomized traffic from both requesters
      fork
         rand_driver(0, 60);
         rand_driver(1, 60);
      join
      wait_done();

      for (int i = 0; i < 16; i++) chk("final_ram_word", 64'(ram_mem[i]), 64'(ref_mem[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
